mult_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one iterative start/busy multiplier between NREQ requesters, e.g. the squaring path and the cube-root engine of y = a^2 + b^(1/3) under the two-multiplier budget.
- Grants the multiplier to one requester at a time and drives its start/operand inputs.
- Holds the operands stable for the whole operation, captures the product when busy falls, and returns it with a one-cycle done pulse.

---
 rtl/mult_share_arb.sv | 210 +++++++++++++++++++++
 tb/tb_mult_share_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin arbiter/sequencer that lends one iterative
// start/busy multiplier to NREQ requesters. The winner's operands are latched
// at grant and held on m_a_o/m_b_o until its done pulse. The product is
// captured when busy falls.
// Optional build macro MULT_ARB_TIMEOUT_EN adds err_o and a watchdog. The
// watchdog forces DONE (f_o=0, err_o=1) after more than TIMEOUT cycles in
// ISSUE/RUN.
module mult_share_arb #(
    parameter int NREQ    = 2,
    parameter int W       = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*W-1:0] a_i,
    input  logic [NREQ*W-1:0] b_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   done_o,
    output logic [2*W-1:0]    f_o,
    output logic              m_start_o,
    output logic [W-1:0]      m_a_o,
    output logic [W-1:0]      m_b_o,
    input  logic [2*W-1:0]    m_f_i,
    input  logic              m_busy_i
`ifdef MULT_ARB_TIMEOUT_EN
    ,
    output logic              err_o
`endif
);

    localparam int PW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic [2*W-1:0]      f_q, f_d;
    logic                start_q, start_d;
    logic [W-1:0]        ma_q, ma_d;
    logic [W-1:0]        mb_q, mb_d;
    logic [PW-1:0]       ptr_q, ptr_d;

    logic [W-1:0]        a_arr [NREQ];
    logic [W-1:0]        b_arr [NREQ];
    logic                win_found;
    logic [PW-1:0]       win_idx;
    logic                timeout_hit;

    // Unpack the flat operand buses into per-requester words
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = a_i[gi*W +: W];
            assign b_arr[gi] = b_i[gi*W +: W];
        end
    endgenerate

    // Round-robin search: first set request after the last winner, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NREQ;
            if (!win_found && req_i[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Watchdog fires on the (TIMEOUT+1)-th cycle spent in ISSUE/RUN
    always_comb begin
        timeout_hit = (cnt_q == CW'(TIMEOUT));
        cnt_d       = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (state_q == S_ISSUE || state_q == S_RUN) begin
            cnt_d = cnt_q + 1'b1;
        end
    end
`else
    // Watchdog compiled out: the expression is constant false
    always_comb begin
        timeout_hit = (TIMEOUT < 0);
    end
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        f_d     = f_q;
        start_d = start_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        ptr_d   = ptr_q;
`ifdef MULT_ARB_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    ma_d           = a_arr[win_idx];
                    mb_d           = b_arr[win_idx];
                    start_d        = 1'b1;
                    ptr_d          = win_idx;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (timeout_hit) begin
                    f_d     = '0;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    start_d = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                    state_d = S_DONE;
                end else if (m_busy_i) begin
                    start_d = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!m_busy_i) begin
                    f_d     = m_f_i;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    f_d     = '0;
                    done_d  = gnt_q;
                    gnt_d   = '0;
`ifdef MULT_ARB_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Done cycle never arbitrates, so ops are separated by an IDLE cycle
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            f_q     <= '0;
            start_q <= 1'b0;
            ma_q    <= '0;
            mb_q    <= '0;
            ptr_q   <= PW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            f_q     <= f_d;
            start_q <= start_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    // Watchdog counter and error pulse registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

    assign gnt_o     = gnt_q;
    assign done_o    = done_q;
    assign f_o       = f_q;
    assign m_start_o = start_q;
    assign m_a_o     = ma_q;
    assign m_b_o     = mb_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Testbench for mult_share_arb: a bench multiplier model, a transaction-level
// reference model of the arbiter, a per-cycle compare process, directed
// scenarios with literal expectations, then a randomized phase.
// Honours MULT_ARB_TIMEOUT_EN (err_o port, TIMEOUT=20 watchdog).
module tb_mult_share_arb;

    localparam int NREQ = 2;
    localparam int W    = 8;
    localparam int T    = 20;
`ifdef MULT_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req;
    logic [15:0]     a_bus, b_bus;
    logic [1:0]      gnt, done;
    logic [15:0]     f;
    logic            m_start;
    logic [7:0]      m_a, m_b;
    logic [15:0]     m_f;
    logic            m_busy;
    logic            err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit stuck  = 1'b0;
    int ndone  = 0;

    always #5 clk = ~clk;

    mult_share_arb #(.NREQ(NREQ), .W(W), .TIMEOUT(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .a_i       (a_bus),
        .b_i       (b_bus),
        .gnt_o     (gnt),
        .done_o    (done),
        .f_o       (f),
        .m_start_o (m_start),
        .m_a_o     (m_a),
        .m_b_o     (m_b),
        .m_f_i     (m_f),
        .m_busy_i  (m_busy)
`ifdef MULT_ARB_TIMEOUT_EN
        ,
        .err_o     (err)
`endif
    );

`ifndef MULT_ARB_TIMEOUT_EN
    assign err = 1'b0;
`endif

    // Bench multiplier: busy rises one cycle after start, stays high b+2
    // cycles, and reads its operands live when it finishes
    int m_cnt;
    always @(posedge clk) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_f    <= '0;
        end else if (m_busy) begin
            if (!stuck) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_f    <= {8'd0, m_a} * {8'd0, m_b};
                end
                m_cnt <= m_cnt - 1;
            end
        end else if (m_start) begin
            m_busy <= 1'b1;
            m_cnt  <= int'(m_b) + 2;
        end
    end

    // Round-robin choice: first requester after the last winner
    function automatic int rr_pick(input logic [1:0] r, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference model: owner of the multiplier, whether busy has been seen,
    // and a one-cycle cool-down after each completion
    logic [1:0]  e_gnt, e_done;
    logic [15:0] e_f;
    logic        e_start, e_err;
    logic [7:0]  e_a, e_b;
    int          e_ptr, e_owner, e_tcnt, w_tmp;
    bit          e_cool, e_seen;

    always @(posedge clk) begin
        if (!rst) begin
            e_gnt <= '0; e_done <= '0; e_f <= '0; e_start <= 1'b0; e_err <= 1'b0;
            e_a <= '0; e_b <= '0; e_ptr <= NREQ - 1; e_owner <= -1;
            e_cool <= 1'b0; e_seen <= 1'b0; e_tcnt <= 0;
        end else begin
            e_done <= '0;
            e_err  <= 1'b0;
            if (e_cool) begin
                e_cool <= 1'b0;
            end else if (e_owner < 0) begin
                w_tmp = rr_pick(req, e_ptr);
                if (w_tmp >= 0) begin
                    e_owner <= w_tmp;
                    e_ptr   <= w_tmp;
                    e_gnt   <= 2'(1 << w_tmp);
                    e_a     <= a_bus[w_tmp*8 +: 8];
                    e_b     <= b_bus[w_tmp*8 +: 8];
                    e_start <= 1'b1;
                    e_seen  <= 1'b0;
                    e_tcnt  <= 0;
                end
            end else begin
                e_tcnt <= e_tcnt + 1;
                if (!e_seen && TMO_EN && e_tcnt == T) begin
                    e_f <= '0; e_done <= 2'(1 << e_owner); e_err <= 1'b1;
                    e_gnt <= '0; e_start <= 1'b0; e_owner <= -1; e_cool <= 1'b1;
                end else if (!e_seen) begin
                    if (m_busy) begin
                        e_seen  <= 1'b1;
                        e_start <= 1'b0;
                    end
                end else if (!m_busy) begin
                    e_f <= {8'd0, e_a} * {8'd0, e_b};
                    e_done <= 2'(1 << e_owner);
                    e_gnt <= '0; e_owner <= -1; e_cool <= 1'b1;
                end else if (TMO_EN && e_tcnt == T) begin
                    e_f <= '0; e_done <= 2'(1 << e_owner); e_err <= 1'b1;
                    e_gnt <= '0; e_owner <= -1; e_cool <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt", 32'(gnt), 32'(e_gnt));
            check("done", 32'(done), 32'(e_done));
            check("f", 32'(f), 32'(e_f));
            check("start", 32'(m_start), 32'(e_start));
            check("m_a", 32'(m_a), 32'(e_a));
            check("m_b", 32'(m_b), 32'(e_b));
            check("err", 32'(err), 32'(e_err));
        end
    end

    // One line per completed operation
    always @(negedge clk) begin
        if (done != 0) begin
            ndone++;
            $display("op done=%b f=%0d err=%b", done, f, err);
        end
    end

    task automatic wait_done(input int max);
        int n = 0;
        @(negedge clk);
        while (done == 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (done == 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no done pulse within %0d cycles", max);
        end
    endtask

    logic [1:0]  seq_done [3];
    logic [15:0] seq_f [3];
    int          nd0, cnt;

    initial begin
        rst = 1'b0; req = '0; a_bus = '0; b_bus = '0;
        seq_done[0] = 2'b01; seq_done[1] = 2'b10; seq_done[2] = 2'b01;
        seq_f[0] = 16'd9; seq_f[1] = 16'd20; seq_f[2] = 16'd9;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_f", 32'(f), 32'd0);
        check("rst_start", 32'(m_start), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single request: a=7, b=9
        a_bus = 16'h0007; b_bus = 16'h0009; req = 2'b01;
        @(negedge clk);
        check("single_gnt", 32'(gnt), 32'd1);
        check("single_start", 32'(m_start), 32'd1);
        check("single_ma", 32'(m_a), 32'd7);
        wait_done(100);
        check("single_done", 32'(done), 32'd1);
        check("single_f", 32'(f), 32'd63);
        check("single_gnt_clr", 32'(gnt), 32'd0);
        req = 2'b00;
        repeat (3) @(negedge clk);

        // Contention held from reset: req0 3*3, req1 5*4, alternating
        a_bus = {8'd5, 8'd3}; b_bus = {8'd4, 8'd3}; req = 2'b11; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_done(100);
            check("cont_done", 32'(done), 32'(seq_done[i]));
            check("cont_f", 32'(f), 32'(seq_f[i]));
        end
        req = 2'b00;
        repeat (3) @(negedge clk);

        // Operand stability and request dropped while granted
        a_bus = 16'h0007; b_bus = 16'h0005; req = 2'b01;
        @(negedge clk);
        check("stab_gnt", 32'(gnt), 32'd1);
        req = 2'b00;
        repeat (2) @(negedge clk);
        a_bus = 16'h00C8;
        wait_done(100);
        check("stab_done", 32'(done), 32'd1);
        check("stab_f", 32'(f), 32'd35);
        repeat (3) @(negedge clk);

        // Reset while running: pointer returns so req0 wins again
        a_bus = {8'd2, 8'd6}; b_bus = {8'd3, 8'd10}; req = 2'b01;
        cnt = 0;
        while (!m_busy && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("rstrun_busy", 32'(m_busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rstrun_gnt", 32'(gnt), 32'd0);
        check("rstrun_ma", 32'(m_a), 32'd0);
        check("rstrun_start", 32'(m_start), 32'd0);
        rst = 1'b1; req = 2'b11;
        wait_done(100);
        check("rstrun_done0", 32'(done), 32'd1);
        check("rstrun_f0", 32'(f), 32'd60);
        wait_done(100);
        check("rstrun_done1", 32'(done), 32'd2);
        check("rstrun_f1", 32'(f), 32'd6);
        req = 2'b00;
        repeat (3) @(negedge clk);

        // Multiplier that never finishes
        stuck = 1'b1; a_bus = 16'h0001; b_bus = 16'h0001; req = 2'b01;
        @(negedge clk);
        req = 2'b00;
`ifdef MULT_ARB_TIMEOUT_EN
        wait_done(60);
        check("tmo_done", 32'(done), 32'd1);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_f", 32'(f), 32'd0);
`else
        nd0 = ndone;
        repeat (60) @(negedge clk);
        check("stuck_no_done", 32'(ndone - nd0), 32'd0);
`endif
        rst = 1'b0; stuck = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Randomized traffic against the model
        nd0 = ndone;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
            a_bus = 16'($urandom);
            b_bus = 16'($urandom) & (($urandom_range(0, 31) == 0) ? 16'hFFFF : 16'h0F0F);
            @(negedge clk);
        end
        req = 2'b00;
        repeat (600) @(negedge clk);
        check("rand_ops_seen", 32'(ndone - nd0 >= 20), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
